// File: rtl/rep_str_seq_pkg.sv
// ---------------------------------------------------------------------------
// rep_str_seq_pkg
// Shared execute-stage definitions used by the string-instruction sequencer:
// FSM state encoding, string op codes, secondary ALU op constants, and two
// small helpers that describe the per-op state walk.
// ---------------------------------------------------------------------------
package rep_str_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_UPD_SI = 3'd3,
    ST_UPD_DI = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_MOVS = 2'b00,
    OP_STOS = 2'b01,
    OP_LODS = 2'b10,
    OP_RSVD = 2'b11
  } str_op_t;

  localparam logic [3:0] ALU2_PASS_SR1 = 4'b0000;
  localparam logic [3:0] ALU2_PTR_STEP = 4'b0101;
  localparam logic [3:0] ALU2_ESP_INC  = 4'b0100;
  localparam logic [3:0] ALU2_ESP_DEC  = 4'b0110;

  // First state of one iteration: STOS has no read phase.
  function automatic state_t first_state(input str_op_t op);
    return (op == OP_STOS) ? ST_WR : ST_RD;
  endfunction

  // Last pointer update of an iteration; this is where ECX is decremented.
  function automatic logic is_final(input state_t s, input str_op_t op);
    return (s == ST_UPD_DI) || (s == ST_UPD_SI && op == OP_LODS);
  endfunction

endpackage

// File: rtl/rep_str_seq.sv
// ---------------------------------------------------------------------------
// rep_str_seq
// Execute-stage sequencer for MOVS/STOS/LODS (optionally REP-prefixed).
// Walks each element through read, write and pointer-step states, drives the
// secondary ALU pointer-step path, decrements ECX per REP iteration and
// stalls upstream until the instruction retires with a one-cycle done pulse.
//
// Optional feature macro: REP_STR_INTR_EN
//   defined   -> i_intr_pend port exists; a pending interrupt ends a REP
//                instruction after the current iteration (ECX holds the
//                remaining count so the instruction can resume).
//   undefined -> no interrupt port; REP always runs to completion.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           decoded string instruction valid (sampled in IDLE)
//   i_str_op          00 MOVS, 01 STOS, 10 LODS, 11 reserved (NOP)
//   i_rep             REP prefix present
//   i_ecx_in          ECX at start
//   i_df_in           direction flag (consumed by the ALU step path)
//   o_mem_rd_req/i_mem_rd_ack   element read handshake
//   o_mem_wr_req/i_mem_wr_ack   element write handshake
//   o_alu2_op         secondary ALU op select
//   o_ptr_sel         pointer on ALU sr2: 0 ESI, 1 EDI
//   o_ptr_we          write ALU result to selected pointer
//   o_ecx_we/o_ecx_out  ECX write strobe and decremented count
//   o_stall           hold upstream stages
//   o_done            one-cycle retire pulse
//   i_intr_pend       interrupt pending (REP_STR_INTR_EN only)
// ---------------------------------------------------------------------------
module rep_str_seq
  import rep_str_seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_str_op,
  input  logic             i_rep,
  input  logic [CNT_W-1:0] i_ecx_in,
  input  logic             i_df_in,
  output logic             o_mem_rd_req,
  input  logic             i_mem_rd_ack,
  output logic             o_mem_wr_req,
  input  logic             i_mem_wr_ack,
  output logic [3:0]       o_alu2_op,
  output logic             o_ptr_sel,
  output logic             o_ptr_we,
  output logic             o_ecx_we,
  output logic [CNT_W-1:0] o_ecx_out,
  output logic             o_stall,
`ifdef REP_STR_INTR_EN
  input  logic             i_intr_pend,
`endif
  output logic             o_done
);

  state_t           r_state;
  str_op_t          r_op;
  logic             r_rep;
  logic [CNT_W-1:0] r_cnt;

  // Registered outputs, decoded from the state being entered.
  logic             r_rd_req;
  logic             r_wr_req;
  logic [3:0]       r_alu2_op;
  logic             r_ptr_sel;
  logic             r_ptr_we;
  logic             r_ecx_we;
  logic [CNT_W-1:0] r_ecx_out;
  logic             r_done;
  logic             r_busy;

  state_t           w_state_next;
  str_op_t          w_op_next;
  logic             w_rep_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_final;
  logic             w_final_next;
  logic             w_intr_exit;
  logic             w_df_unused;

  // The step sign is applied inside the ALU; the flag is not needed here.
  assign w_df_unused = i_df_in;

`ifdef REP_STR_INTR_EN
  assign w_intr_exit = i_intr_pend;
`else
  assign w_intr_exit = 1'b0;
`endif

  assign w_cnt_dec = r_cnt - CNT_W'(1);
  assign w_final   = is_final(r_state, r_op);

  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_rep_next   = r_rep;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_op_next  = str_op_t'(i_str_op);
          w_rep_next = i_rep;
          w_cnt_next = i_ecx_in;
          // REP with ECX==0 performs zero iterations.
          if (i_str_op == OP_RSVD || (i_rep && i_ecx_in == '0)) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = first_state(str_op_t'(i_str_op));
          end
        end
      end
      ST_RD: begin
        if (i_mem_rd_ack) begin
          w_state_next = (r_op == OP_LODS) ? ST_UPD_SI : ST_WR;
        end
      end
      ST_WR: begin
        if (i_mem_wr_ack) begin
          w_state_next = (r_op == OP_MOVS) ? ST_UPD_SI : ST_UPD_DI;
        end
      end
      ST_UPD_SI, ST_UPD_DI: begin
        if (!w_final) begin
          w_state_next = ST_UPD_DI;
        end else if (r_rep) begin
          w_cnt_next = w_cnt_dec;
          if (w_cnt_dec == '0 || w_intr_exit) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = first_state(r_op);
          end
        end else begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_final_next = is_final(w_state_next, w_op_next);

  // Outputs are registered against the next state so they line up with the
  // state they describe; the count only changes in the final state, so
  // w_cnt_next - 1 on entry equals the value written during that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MOVS;
      r_rep     <= 1'b0;
      r_cnt     <= '0;
      r_rd_req  <= 1'b0;
      r_wr_req  <= 1'b0;
      r_alu2_op <= ALU2_PASS_SR1;
      r_ptr_sel <= 1'b0;
      r_ptr_we  <= 1'b0;
      r_ecx_we  <= 1'b0;
      r_ecx_out <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_op      <= w_op_next;
      r_rep     <= w_rep_next;
      r_cnt     <= w_cnt_next;
      r_rd_req  <= (w_state_next == ST_RD);
      r_wr_req  <= (w_state_next == ST_WR);
      r_ptr_we  <= (w_state_next == ST_UPD_SI) || (w_state_next == ST_UPD_DI);
      r_ptr_sel <= (w_state_next == ST_UPD_DI);
      r_alu2_op <= ((w_state_next == ST_UPD_SI) || (w_state_next == ST_UPD_DI)) ?
                   ALU2_PTR_STEP : ALU2_PASS_SR1;
      r_ecx_we  <= w_final_next && w_rep_next;
      r_ecx_out <= (w_final_next && w_rep_next) ? (w_cnt_next - CNT_W'(1)) : '0;
      r_done    <= (w_state_next == ST_DONE);
      r_busy    <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
    end
  end

  assign o_mem_rd_req = r_rd_req;
  assign o_mem_wr_req = r_wr_req;
  assign o_alu2_op    = r_alu2_op;
  assign o_ptr_sel    = r_ptr_sel;
  assign o_ptr_we     = r_ptr_we;
  assign o_ecx_we     = r_ecx_we;
  assign o_ecx_out    = r_ecx_out;
  assign o_done       = r_done;
  // Stall already in the accepting cycle so upstream holds the instruction.
  assign o_stall      = ((r_state == ST_IDLE) && i_start) || r_busy;

endmodule

// File: tb/tb_rep_str_seq.sv
module tb_rep_str_seq;

  localparam int CNT_W = 32;
  localparam int K_RD = 0, K_WR = 1, K_PSI = 2, K_PDI = 3, K_ECX = 4, K_DONE = 5;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       str_op = 2'b00;
  logic             rep = 1'b0;
  logic [CNT_W-1:0] ecx_in = '0;
  logic             df_in = 1'b0;
  logic             intr_pend = 1'b0;
  logic             rd_req, rd_ack, wr_req, wr_ack;
  logic [3:0]       alu2_op;
  logic             ptr_sel, ptr_we, ecx_we, stall, done;
  logic [CNT_W-1:0] ecx_out;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   s0 = 0;
  int   rd_delay = 0;
  int   wr_delay = 0;
  int   rd_wait = 0;
  int   wr_wait = 0;
  bit   mon_en = 1'b0;
  ev_t  sb[$];

  rep_str_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(start),
    .i_str_op(str_op),
    .i_rep(rep),
    .i_ecx_in(ecx_in),
    .i_df_in(df_in),
    .o_mem_rd_req(rd_req),
    .i_mem_rd_ack(rd_ack),
    .o_mem_wr_req(wr_req),
    .i_mem_wr_ack(wr_ack),
    .o_alu2_op(alu2_op),
    .o_ptr_sel(ptr_sel),
    .o_ptr_we(ptr_we),
    .o_ecx_we(ecx_we),
    .o_ecx_out(ecx_out),
    .o_stall(stall),
`ifdef REP_STR_INTR_EN
    .i_intr_pend(intr_pend),
`endif
    .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: ack comes after the request has waited the programmed delay.
  assign rd_ack = rd_req && (rd_wait >= rd_delay);
  assign wr_ack = wr_req && (wr_wait >= wr_delay);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wait <= 0;
      wr_wait <= 0;
    end else begin
      rd_wait <= (rd_req && !rd_ack) ? rd_wait + 1 : 0;
      wr_wait <= (wr_req && !wr_ack) ? wr_wait + 1 : 0;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Monitor: pops one expected event per observed DUT event.
  task automatic mon_pop(input int kind, input int val);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected event: got kind %0d val %0d at cycle %0d, expected none",
               kind, val, cyc - s0);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc - s0) begin
        fails++;
        $display("[TB] FAIL event: got kind %0d val %0d cycle %0d, expected kind %0d val %0d cycle %0d",
                 kind, val, cyc - s0, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (rd_req && rd_ack) mon_pop(K_RD, 0);
      if (wr_req && wr_ack) mon_pop(K_WR, 0);
      if (ptr_we) begin
        mon_pop(ptr_sel ? K_PDI : K_PSI, 0);
        check("alu2_op step", alu2_op, 4'b0101);
      end
      if (ecx_we) mon_pop(K_ECX, int'(ecx_out));
      if (done) mon_pop(K_DONE, 0);
    end
  end

  // Builds the expected event list from the op description, then issues it.
  task automatic run_op(input string name, input int op, input bit r, input int ecx,
                        input int rdd, input int wrd, input int stop_after, input int intr_cyc);
    int  t, cnt, it, n;
    bit  stall_ok;
    t = 1;
    cnt = ecx;
    it = 0;
    if (op == 3 || (r && ecx == 0)) begin
      push(K_DONE, 0, 1);
    end else begin
      forever begin
        it++;
        if (op != 1) begin push(K_RD, 0, t + rdd); t += rdd + 1; end
        if (op != 2) begin push(K_WR, 0, t + wrd); t += wrd + 1; end
        if (op != 1) begin push(K_PSI, 0, t); t++; end
        if (op != 2) begin push(K_PDI, 0, t); t++; end
        if (r) begin push(K_ECX, cnt - 1, t - 1); cnt--; end
        if (!r || cnt == 0 || it == stop_after) break;
      end
      push(K_DONE, 0, t);
    end

    rd_delay = rdd;
    wr_delay = wrd;
    @(negedge clk);
    start = 1'b1;
    str_op = op[1:0];
    rep = r;
    ecx_in = ecx;
    s0 = cyc;
    #1 check({name, " stall on start"}, stall, 1);
    @(negedge clk);
    start = 1'b0;
    stall_ok = 1'b1;
    n = 0;
    while (!done && n < 300) begin
      if (!stall) stall_ok = 1'b0;
      if (intr_cyc > 0 && cyc - s0 >= intr_cyc) intr_pend = 1'b1;
      @(negedge clk);
      n++;
    end
    check({name, " done within budget"}, done, 1);
    check({name, " stall held until done"}, stall_ok, 1);
    check({name, " done latency"}, cyc - s0, t);
    check({name, " stall low in done"}, stall, 0);
    intr_pend = 1'b0;
    @(negedge clk);
    check({name, " scoreboard drained"}, sb.size(), 0);
    sb.delete();
    $display("[TB] txn %s op=%0d rep=%0d ecx=%0d done@%0d", name, op, r, ecx, t);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {rd_req, wr_req, alu2_op, ptr_sel, ptr_we, ecx_we, stall, done, ecx_out}, 0);
  endtask

  initial begin
    #12;
    check_idle_outputs("reset outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    run_op("movs", 0, 1'b0, 9, 0, 0, 0, 0);
    run_op("rep_stos3", 1, 1'b1, 3, 0, 2, 0, 0);
    run_op("rep_lods0", 2, 1'b1, 0, 0, 0, 0, 0);
    run_op("rsvd", 3, 1'b0, 7, 0, 0, 0, 0);
    run_op("lods_wait", 2, 1'b0, 4, 1, 0, 0, 0);
    run_op("rep_movs2", 0, 1'b1, 2, 1, 0, 0, 0);

    // Reset while a write request is outstanding.
    mon_en = 1'b0;
    wr_delay = 5;
    @(negedge clk);
    start = 1'b1;
    str_op = 2'b01;
    rep = 1'b1;
    ecx_in = 3;
    @(negedge clk);
    start = 1'b0;
    check("wr_req before reset", wr_req, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("outputs during mid-op reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    run_op("movs_after_reset", 0, 1'b0, 1, 0, 0, 0, 0);

`ifdef REP_STR_INTR_EN
    run_op("rep_movs5_intr", 0, 1'b1, 5, 0, 0, 2, 6);
`else
    run_op("rep_movs5_intr", 0, 1'b1, 5, 0, 0, 0, 6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
